// File: rtl/if_id_pipe_pkg.sv
// Shared definitions for the IF/ID pipeline stage.
// Reset level, default widths, data defaults and state encoding.
package if_id_pipe_pkg;

    localparam logic RST_ACT = 1'b0;

    localparam int PC_W_DEF   = 32;
    localparam int INST_W_DEF = 32;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    function automatic logic [1:0] occ_of(input state_t s);
        return s;
    endfunction

endpackage

// File: rtl/pipe_ent.sv
// One pipeline entry: valid flag plus PC/instruction register.
// Clear returns the data to its idle default and dominates load.
module pipe_ent
    import if_id_pipe_pkg::*;
#(
    parameter int                PC_W     = PC_W_DEF,
    parameter int                INST_W   = INST_W_DEF,
    parameter logic [INST_W-1:0] NOP_INST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clr,
    input  logic [PC_W-1:0]   d_pc,
    input  logic [INST_W-1:0] d_inst,
    output logic              valid,
    output logic [PC_W-1:0]   pc,
    output logic [INST_W-1:0] inst
);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACT) begin
            valid <= 1'b0;
            pc    <= '0;
            inst  <= NOP_INST;
        end else if (clr) begin
            valid <= 1'b0;
            pc    <= '0;
            inst  <= NOP_INST;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= d_pc;
            inst  <= d_inst;
        end
    end

endmodule

// File: rtl/if_id_pipe.sv
// IF/ID stage: valid/ready handshake, flush, optional skid entry.
// Main entry drives decode; skid entry absorbs one pair under stall.
module if_id_pipe
    import if_id_pipe_pkg::*;
#(
    parameter int                PC_W     = PC_W_DEF,
    parameter int                INST_W   = INST_W_DEF,
    parameter logic [INST_W-1:0] NOP_INST = '0,
    parameter bit                SKID     = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [1:0]        occ
);

    state_t state_q;
    state_t state_d;

    logic in_fire;
    logic out_fire;

    logic m_load;
    logic m_clr;
    logic m_from_skid;
    logic s_load;
    logic s_clr;

    logic              m_valid;
    logic [PC_W-1:0]   m_pc;
    logic [INST_W-1:0] m_inst;
    logic [PC_W-1:0]   m_dpc;
    logic [INST_W-1:0] m_dinst;

    logic              s_valid;
    logic [PC_W-1:0]   s_pc;
    logic [INST_W-1:0] s_inst;

    assign in_fire  = in_valid & in_ready & ~flush;
    assign out_fire = m_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        m_load      = 1'b0;
        m_clr       = 1'b0;
        m_from_skid = 1'b0;
        s_load      = 1'b0;
        s_clr       = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
            m_clr   = 1'b1;
            s_clr   = 1'b1;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        m_load  = 1'b1;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        m_load = 1'b1;
                    end else if (in_fire && SKID) begin
                        s_load  = 1'b1;
                        state_d = ST_TWO;
                    end else if (out_fire) begin
                        m_clr   = 1'b1;
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        m_load      = 1'b1;
                        m_from_skid = 1'b1;
                        s_clr       = 1'b1;
                        state_d     = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    m_clr   = 1'b1;
                    s_clr   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACT) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Skid drains into main first, preserving FIFO order.
    assign m_dpc   = m_from_skid ? s_pc   : in_pc;
    assign m_dinst = m_from_skid ? s_inst : in_inst;

    pipe_ent #(
        .PC_W     (PC_W),
        .INST_W   (INST_W),
        .NOP_INST (NOP_INST)
    ) u_main (
        .clk    (clk),
        .rst    (rst),
        .load   (m_load),
        .clr    (m_clr),
        .d_pc   (m_dpc),
        .d_inst (m_dinst),
        .valid  (m_valid),
        .pc     (m_pc),
        .inst   (m_inst)
    );

    generate
        if (SKID) begin : g_skid
            pipe_ent #(
                .PC_W     (PC_W),
                .INST_W   (INST_W),
                .NOP_INST (NOP_INST)
            ) u_skid (
                .clk    (clk),
                .rst    (rst),
                .load   (s_load),
                .clr    (s_clr),
                .d_pc   (in_pc),
                .d_inst (in_inst),
                .valid  (s_valid),
                .pc     (s_pc),
                .inst   (s_inst)
            );
            // Skid valid is a flop, so ready is cut from out_ready.
            assign in_ready = ~s_valid;
        end else begin : g_noskid
            assign s_valid  = 1'b0;
            assign s_pc     = '0;
            assign s_inst   = NOP_INST;
            assign in_ready = ~m_valid | out_ready;
        end
    endgenerate

    assign out_valid = m_valid;
    assign out_pc    = m_pc;
    assign out_inst  = m_inst;
    assign occ       = occ_of(state_q);

    a_idle_data: assert property (
        @(posedge clk) disable iff (rst == RST_ACT)
        !out_valid |-> (out_pc == '0 && out_inst == NOP_INST)
    );

    a_state_valid: assert property (
        @(posedge clk) disable iff (rst == RST_ACT)
        (state_q != ST_EMPTY) == m_valid
    );

    a_skid_match: assert property (
        @(posedge clk) disable iff (rst == RST_ACT)
        (state_q == ST_TWO) == s_valid
    );

endmodule

// File: tb/tb_if_id_pipe.sv
// Bench for if_id_pipe: SKID=1 and SKID=0 instances on shared stimulus,
// queue model compared every cycle plus directed literal checks.
module tb_if_id_pipe;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid;
    logic        flush;
    logic        out_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;

    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_pc, s_out_inst;
    logic [1:0]  s_occ;
    logic        n_in_ready, n_out_valid;
    logic [31:0] n_out_pc, n_out_inst;
    logic [1:0]  n_occ;

    if_id_pipe #(
        .PC_W(32), .INST_W(32), .NOP_INST(NOP), .SKID(1'b1)
    ) u_skid (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .flush(flush),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_pc(s_out_pc), .out_inst(s_out_inst), .occ(s_occ)
    );

    if_id_pipe #(
        .PC_W(32), .INST_W(32), .NOP_INST(NOP), .SKID(1'b0)
    ) u_nos (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(n_in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .flush(flush),
        .out_valid(n_out_valid), .out_ready(out_ready),
        .out_pc(n_out_pc), .out_inst(n_out_inst), .occ(n_occ)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t qs[$];
    ent_t qn[$];

    int checks = 0;
    int errors = 0;

    bit          mono_s, mono_n;
    bit          have_s, have_n;
    logic [31:0] last_s, last_n;
    int          deliv_n, acc_n;

    function automatic logic [31:0] inst_of(input logic [31:0] p);
        return {16'hA5A5, p[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] pc,
                         input bit ordy, input bit fl);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst_of(pc);
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic newphase(input bit ms, input bit mn);
        mono_s  = ms;
        mono_n  = mn;
        have_s  = 1'b0;
        have_n  = 1'b0;
        deliv_n = 0;
        acc_n   = 0;
    endtask

    task automatic compare();
        logic        mv;
        logic [31:0] mpc, minst;
        mv = qs.size() > 0;
        mpc = 32'h0;
        minst = NOP;
        if (mv) begin
            mpc = qs[0].pc;
            minst = qs[0].inst;
        end
        chk("s_out_valid", 64'(s_out_valid), 64'(mv));
        chk("s_out_pc", 64'(s_out_pc), 64'(mpc));
        chk("s_out_inst", 64'(s_out_inst), 64'(minst));
        chk("s_occ", 64'(s_occ), 64'(qs.size()));
        chk("s_in_ready", 64'(s_in_ready), 64'(qs.size() < 2));
        mv = qn.size() > 0;
        mpc = 32'h0;
        minst = NOP;
        if (mv) begin
            mpc = qn[0].pc;
            minst = qn[0].inst;
        end
        chk("n_out_valid", 64'(n_out_valid), 64'(mv));
        chk("n_out_pc", 64'(n_out_pc), 64'(mpc));
        chk("n_out_inst", 64'(n_out_inst), 64'(minst));
        chk("n_occ", 64'(n_occ), 64'(qn.size()));
        chk("n_in_ready", 64'(n_in_ready), 64'(!mv || out_ready));
    endtask

    // Called at negedge+1 with inputs set; ends at the next negedge+1.
    task automatic step();
        bit fs, fn, rs, rn, vs, vn;
        #1;
        fs = s_out_valid & out_ready;
        fn = n_out_valid & out_ready;
        if (fs && mono_s) begin
            if (have_s) chk("s_order", 64'(s_out_pc > last_s), 64'd1);
            last_s = s_out_pc;
            have_s = 1'b1;
        end
        if (fn && mono_n) begin
            if (have_n) chk("n_order", 64'(n_out_pc > last_n), 64'd1);
            last_n = n_out_pc;
            have_n = 1'b1;
        end
        if (fn) deliv_n++;
        if (in_valid && n_in_ready && !flush) acc_n++;
        @(posedge clk);
        vs = qs.size() > 0;
        rs = qs.size() < 2;
        vn = qn.size() > 0;
        rn = !vn || out_ready;
        if (flush) begin
            qs.delete();
            qn.delete();
        end else begin
            if (vs && out_ready) void'(qs.pop_front());
            if (in_valid && rs) qs.push_back({in_pc, in_inst});
            if (vn && out_ready) void'(qn.pop_front());
            if (in_valid && rn) qn.push_back({in_pc, in_inst});
        end
        @(negedge clk);
        compare();
        #1;
    endtask

    initial begin
        logic [31:0] pc;
        int          prev;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        newphase(1'b0, 1'b0);

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(s_out_valid), 64'd0);
        chk("rst_out_pc", 64'(s_out_pc), 64'd0);
        chk("rst_out_inst", 64'(s_out_inst), 64'(NOP));
        chk("rst_occ", 64'(s_occ), 64'd0);
        chk("rst_in_ready", 64'(s_in_ready), 64'd1);
        chk("rst_n_in_ready", 64'(n_in_ready), 64'd1);
        rst = 1'b1;

        // Reset mid-stream
        drive(1'b1, 32'h100, 1'b0, 1'b0);
        in_inst = 32'h1234;
        step();
        chk("mid_pre_pc", 64'(s_out_pc), 64'h100);
        chk("mid_pre_inst", 64'(s_out_inst), 64'h1234);
        chk("mid_pre_occ", 64'(s_occ), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_out_valid", 64'(s_out_valid), 64'd0);
        chk("mid_out_pc", 64'(s_out_pc), 64'd0);
        chk("mid_out_inst", 64'(s_out_inst), 64'(NOP));
        chk("mid_occ", 64'(s_occ), 64'd0);
        chk("mid_in_ready", 64'(s_in_ready), 64'd1);
        chk("mid_n_out_valid", 64'(n_out_valid), 64'd0);
        qs.delete();
        qn.delete();
        @(negedge clk);
        #1;
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);

        // Streaming
        newphase(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i * 4), 1'b1, 1'b0);
            step();
            chk("str_s_pc", 64'(s_out_pc), 64'(i * 4));
            chk("str_s_occ", 64'(s_occ), 64'd1);
            chk("str_s_rdy", 64'(s_in_ready), 64'd1);
            chk("str_n_pc", 64'(n_out_pc), 64'(i * 4));
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        chk("str_end_occ", 64'(s_occ), 64'd0);

        // Back-pressure into the skid entry
        newphase(1'b0, 1'b0);
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        step();
        chk("bp1_occ", 64'(s_occ), 64'd1);
        drive(1'b1, 32'h4, 1'b0, 1'b0);
        step();
        chk("bp2_occ", 64'(s_occ), 64'd2);
        chk("bp2_rdy", 64'(s_in_ready), 64'd0);
        chk("bp2_pc", 64'(s_out_pc), 64'h0);
        drive(1'b1, 32'h8, 1'b0, 1'b0);
        step();
        chk("bp3_occ", 64'(s_occ), 64'd2);
        chk("bp3_pc", 64'(s_out_pc), 64'h0);
        drive(1'b1, 32'h8, 1'b1, 1'b0);
        step();
        chk("bp4_pc", 64'(s_out_pc), 64'h4);
        chk("bp4_occ", 64'(s_occ), 64'd1);
        chk("bp4_rdy", 64'(s_in_ready), 64'd1);
        drive(1'b1, 32'h8, 1'b1, 1'b0);
        step();
        chk("bp5_pc", 64'(s_out_pc), 64'h8);
        chk("bp5_inst", 64'(s_out_inst), 64'hA5A5_0008);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        chk("bp6_valid", 64'(s_out_valid), 64'd0);
        chk("bp6_inst", 64'(s_out_inst), 64'(NOP));

        // Flush while holding two entries
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h14, 1'b0, 1'b0);
        step();
        chk("fl_pre_occ", 64'(s_occ), 64'd2);
        drive(1'b1, 32'h20, 1'b0, 1'b1);
        step();
        chk("fl_valid", 64'(s_out_valid), 64'd0);
        chk("fl_occ", 64'(s_occ), 64'd0);
        chk("fl_rdy", 64'(s_in_ready), 64'd1);
        chk("fl_inst", 64'(s_out_inst), 64'(NOP));
        chk("fl_n_valid", 64'(n_out_valid), 64'd0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            step();
            chk("fl_post_valid", 64'(s_out_valid), 64'd0);
        end

        // SKID=0 with out_ready toggling, fetch holds until accepted
        newphase(1'b0, 1'b1);
        pc = 32'h200;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, pc, (i % 2) == 1, 1'b0);
            prev = acc_n;
            step();
            if (acc_n != prev) pc = pc + 32'h4;
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        step();
        chk("tog_acc", 64'(acc_n), 64'd11);
        chk("tog_deliv", 64'(deliv_n), 64'(acc_n));

        // Random soak, unique PC per cycle
        newphase(1'b1, 1'b1);
        pc = 32'h1000;
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 9) < 7, pc,
                  $urandom_range(0, 9) < 6,
                  $urandom_range(0, 19) == 0);
            step();
            pc = pc + 32'h4;
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            step();
        end
        chk("soak_s_occ", 64'(s_occ), 64'd0);
        chk("soak_n_occ", 64'(n_occ), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_pipe.md
# if_id_pipe

Parametrised IF/ID pipeline stage with a valid/ready handshake, flush, and an optional two-entry skid buffer. It sits between the fetch unit and the decoder. It carries one PC/instruction pair per cycle at full throughput. It lets decode back-pressure fetch, and with `SKID=1` it breaks the combinational ready path. Branch/exception logic uses it to kill in-flight fetches.

## Interface
- `PC_W`, default 32: PC width in bits.
- `INST_W`, default 32: instruction width in bits.
- `NOP_INST`, default 0 (`INST_W` bits): value driven on `out_inst` when no valid entry is held.
- `SKID`, default 1: 1 selects the skid buffer with registered `in_ready`; 0 selects a single register with combinational `in_ready`.
- `clk`, in, 1: rising-edge clock.
- `rst`, in, 1: reset, asynchronous, active-low (asserted at 0).
- `in_valid`, in, 1: fetch presents a valid pair.
- `in_ready`, out, 1: stage accepts the pair this cycle.
- `in_pc`, in, `PC_W`: fetched PC.
- `in_inst`, in, `INST_W`: fetched instruction.
- `flush`, in, 1: discard all held and incoming entries.
- `out_valid`, out, 1: pair presented to decode is valid.
- `out_ready`, in, 1: decode consumes the pair this cycle.
- `out_pc`, out, `PC_W`: PC to decode.
- `out_inst`, out, `INST_W`: instruction to decode.
- `occ`, out, 2: entries currently held (0..2; max 1 when `SKID=0`).

## Operation
- Acceptance is `in_fire = in_valid & in_ready & ~flush`. Consumption is `out_fire = out_valid & out_ready`.
- The stage has two entries: main, which drives the outputs, and skid, which exists only when `SKID=1`. States: EMPTY, ONE (main valid), TWO (main and skid valid).
- Transitions when `flush=0`:
  - EMPTY: on `in_fire`, load main and go to ONE.
  - ONE:
    - `in_fire` with `out_fire`: reload main, stay in ONE.
    - `in_fire` without `out_fire`: load skid, go to TWO.
    - `out_fire` only: go to EMPTY.
  - TWO: `in_ready=0`. On `out_fire`, move skid to main and go to ONE.
- Ordering is strictly FIFO. Pairs are never dropped or duplicated except by flush.
- `in_ready`:
  - `SKID=1`: registered and equal to `~(state==TWO)`. It has no combinational dependence on `out_ready`.
  - `SKID=0`: `~out_valid | out_ready`.
- Flush:
  - Next state is EMPTY regardless of `in_valid`/`out_ready`.
  - The same-cycle input is discarded.
  - A same-cycle `out_fire` still counts as consumed by decode.
  - `flush` dominates every other event.
- When an entry is invalid, its data registers load 0 (PC) and `NOP_INST` (instruction), so `out_pc=0` and `out_inst=NOP_INST` whenever `out_valid=0`.
- Reset, at any time including mid-transfer:
  - State EMPTY, `out_valid=0`, `out_pc=0`, `out_inst=NOP_INST`, `occ=0`.
  - `in_ready=1` when `SKID=1`; when `SKID=0` it follows its combinational equation.
  - Deassertion is assumed synchronised externally. The first acceptance can occur on the first rising edge after `rst` goes high.

## Timing
- Latency is 1 cycle: a pair accepted at edge N is on the outputs after edge N.
- Throughput is 1 pair/cycle with `out_ready` held high, in both modes.
- With `SKID=1`, a `out_ready` drop at cycle N stalls fetch from cycle N+1. The skid entry absorbs the pair accepted at cycle N.
- Flush asserted in cycle N gives `out_valid=0` after edge N.
- `occ` is registered and updates on the same edge as state.

## Structure
- Shared defs package holds:
  - reset-asserted level constant (0);
  - default PC/instruction widths;
  - zero-word and NOP constants;
  - 2-bit state encoding (EMPTY=0, ONE=1, TWO=2).
- One sub-module, `pipe_ent`: a valid flag plus data register with load, clear-to-default, and async active-low reset. It is instantiated once for main and once for skid (generate on `SKID`).
- The parent holds the FSM, handshake and flush logic.

## Test plan
- Reset mid-stream:
  - Stimulus: drive `in_valid=1`, `in_pc=0x100`, `in_inst=0x1234`, then pull `rst` low between edges.
  - Required: outputs go to `out_valid=0`, `out_pc=0`, `out_inst=NOP_INST`, `occ=0` immediately, without waiting for an edge.
- Streaming:
  - Stimulus: `out_ready=1`; push PCs 0x0, 0x4, 0x8, 0xC on consecutive cycles.
  - Required: each appears one cycle later; `in_ready` stays high; `occ=1` throughout.
- Back-pressure (`SKID=1`):
  - Stimulus: `out_ready=0` from cycle 3 while pushing 0x0, 0x4, 0x8.
  - Required: `occ` reaches 2 and `in_ready` falls the next cycle. After `out_ready` returns, 0x0, 0x4, 0x8 emerge in order with no loss.
- Flush:
  - Stimulus: in state TWO, assert `flush` together with `in_valid` (PC 0x20).
  - Required: next cycle `out_valid=0`, `occ=0`, `in_ready=1`; 0x20 never appears.
- `SKID=0` mode:
  - Stimulus: `out_ready` toggles every cycle while fetch pushes continuously.
  - Required: `in_ready` equals `~out_valid | out_ready` in every cycle; every accepted PC is delivered exactly once.
- Random soak (both modes):
  - Stimulus: random `in_valid`/`out_ready`/`flush` for 10k cycles.
  - Required: a scoreboard confirms FIFO order, no duplicates, and flushed entries removed.
